vmem_arbiter: RTL and testbench
===============================

Name: vmem_arbiter

Overview:
- Owns the single system memory port (Addr/RD/WR/DataOut/DataIn).
- Shares that port between two requesters:
  - the instruction fetch path: single-word reads;
  - the vector load/store engine: fixed-length bursts of consecutive words, read or write.
- Generates burst addresses, element indices and memory strobes.
- Sits between the core control FSM and the memory bus.

Parameters:
BURST_LEN, 16, words per vector burst (legal 2..256); element counter width = clog2(BURST_LEN).
PRIORITY_RR, 1, 1 = round-robin on simultaneous requests; 0 = fetch always wins.

Ports:
Clk1  in  1  system clock; all state changes on rising edge.
Reset  in  1  asynchronous, active-low reset.
f_req  in  1  fetch request, level; held until f_gnt is seen.
f_addr  in  16  fetch word address; sampled on the granting edge.
f_gnt  out  1  one-cycle pulse: fetch accepted.
f_valid  out  1  one-cycle pulse: f_data valid.
f_data  out  16  fetched word (driven from DataIn when f_valid=1, else 0).
v_req  in  1  vector burst request, level; held until v_gnt is seen.
v_we  in  1  1 = burst write, 0 = burst read; sampled on the granting edge.
v_base  in  16  burst base address; sampled on the granting edge.
v_gnt  out  1  one-cycle pulse: burst accepted.
v_idx  out  clog2(BURST_LEN)  element index of the current read beat or write beat.
v_wready  out  1  write beat: requester must drive v_wdata for element v_idx this cycle.
v_wdata  in  16  write data, combinationally forwarded to DataOut.
v_rvalid  out  1  read beat: v_rdata holds element v_idx.
v_rdata  out  16  read data (DataIn pass-through when v_rvalid=1, else 0).
v_done  out  1  one-cycle pulse on the final beat of a burst.
Addr  out  16  memory address.
RD  out  1  memory read strobe.
WR  out  1  memory write strobe.
DataOut  out  16  memory write data.
DataIn  in  16  memory read data; valid the cycle after RD=1 at that address.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, cnt=0, last_grant=vector (so fetch wins the first tie).
  - All outputs 0.
  - Asserting Reset mid-transaction aborts it immediately: no v_done, no f_valid, RD/WR drop at once.
- States: IDLE, F_RD, F_DATA, V_RD, V_DRAIN, V_WR.
- IDLE:
  - Samples f_req and v_req.
  - Only one request high: grant it.
  - Both high, PRIORITY_RR=1: grant the requester not granted last.
  - Both high, PRIORITY_RR=0: grant fetch.
  - Neither high: stay in IDLE.
  - Requests are only sampled in IDLE; a req withdrawn before grant is dropped silently.
- Fetch transaction (grant edge = E0):
  - Cycle 1, F_RD: f_gnt=1, RD=1, Addr=latched f_addr.
  - Cycle 2, F_DATA: RD=0, f_valid=1, f_data=DataIn.
  - Then IDLE.
- Burst read, v_we=0:
  - Cycles 1..N, V_RD, cnt=0..N-1: RD=1, Addr=base+cnt; v_gnt=1 in cycle 1 only.
  - Cycles 2..N: v_rvalid=1, v_idx=cnt-1.
  - Cycle N+1, V_DRAIN: RD=0, v_rvalid=1, v_idx=N-1, v_done=1.
  - Then IDLE.
- Burst write, v_we=1:
  - Cycles 1..N, V_WR, cnt=0..N-1: WR=1, Addr=base+cnt, v_wready=1, v_idx=cnt, DataOut=v_wdata; v_gnt=1 in cycle 1.
  - Cycle N: v_done=1.
  - Then IDLE.
- Timing and registering:
  - Addr, RD, WR, v_idx are registered.
  - DataOut=v_wdata only while WR=1, else 0.
  - IDLE occupies at least one cycle between any two transactions.
  - A req still high on return to IDLE starts a new transaction.
- Address arithmetic: base+cnt is modulo 2^16 and wraps (0xFFFE+3 = 0x0001). RD and WR are never both 1.
- last_grant updates on every grant. A transaction in progress is never pre-empted.

Test Plan:
1. Reset low, then f_req=1, f_addr=0x0040, memory returns 0x1F0A → f_gnt in cycle 1 with RD=1, Addr=0x0040; cycle 2 f_valid=1, f_data=0x1F0A; IDLE in cycle 3.
2. v_req=1, v_we=0, v_base=0x0100, memory returns Addr^0xFFFF → RD high 16 cycles, Addr 0x0100..0x010F; v_rvalid beats idx 0..15, data 0xFEFF..0xFEF0; v_done on idx 15 only.
3. v_req=1, v_we=1, v_base=0xFFF8, v_wdata=0xA000+v_idx → WR high 16 cycles; Addr 0xFFF8..0xFFFF then 0x0000..0x0007; DataOut 0xA000..0xA00F; v_done in cycle 16.
4. f_req and v_req held high together with PRIORITY_RR=1 → grants alternate fetch, vector, fetch; with PRIORITY_RR=0, fetch wins every tie.
5. Reset pulled low in cycle 7 of a read burst → RD=0, v_rvalid=0, v_done never pulses; after release, f_req is granted normally from IDLE.
6. f_req asserted during a burst write → no f_gnt until the burst's v_done; f_gnt follows within 2 cycles of v_done.

Source files
------------

// File: rtl/vmem_arbiter.sv
// Memory port arbiter: shares one memory port between single-word fetch reads
// and fixed-length vector read/write bursts.
module vmem_arbiter #(
  parameter int unsigned BURST_LEN   = 16,
  parameter bit          PRIORITY_RR = 1'b1
) (
  input  logic                         Clk1,
  input  logic                         Reset,
  input  logic                         f_req,
  input  logic [15:0]                  f_addr,
  output logic                         f_gnt,
  output logic                         f_valid,
  output logic [15:0]                  f_data,
  input  logic                         v_req,
  input  logic                         v_we,
  input  logic [15:0]                  v_base,
  output logic                         v_gnt,
  output logic [$clog2(BURST_LEN)-1:0] v_idx,
  output logic                         v_wready,
  input  logic [15:0]                  v_wdata,
  output logic                         v_rvalid,
  output logic [15:0]                  v_rdata,
  output logic                         v_done,
  output logic [15:0]                  Addr,
  output logic                         RD,
  output logic                         WR,
  output logic [15:0]                  DataOut,
  input  logic [15:0]                  DataIn
);

  localparam int unsigned CntW = $clog2(BURST_LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST_LEN - 1);

  typedef enum logic [2:0] {Idle, FRd, FData, VRd, VDrain, VWr} state_e;

  state_e          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            lastVec, lastVecNext;
  logic [15:0]     addrNext;
  logic            rdNext, wrNext;
  logic [CntW-1:0] idxNext;
  logic            grantF, grantV;

  // lastVec=1 means the vector engine won the previous grant, so fetch wins a tie
  assign grantF = f_req && (!v_req || !PRIORITY_RR || lastVec);
  assign grantV = v_req && !grantF;

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state   <= Idle;
      cnt     <= '0;
      lastVec <= 1'b1;
      Addr    <= '0;
      RD      <= 1'b0;
      WR      <= 1'b0;
      v_idx   <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      lastVec <= lastVecNext;
      Addr    <= addrNext;
      RD      <= rdNext;
      WR      <= wrNext;
      v_idx   <= idxNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = '0;
    lastVecNext = lastVec;
    addrNext    = '0;
    rdNext      = 1'b0;
    wrNext      = 1'b0;
    idxNext     = '0;
    unique case (state)
      Idle: begin
        if (grantF) begin
          stateNext   = FRd;
          addrNext    = f_addr;
          rdNext      = 1'b1;
          lastVecNext = 1'b0;
        end else if (grantV) begin
          stateNext   = v_we ? VWr : VRd;
          addrNext    = v_base;
          rdNext      = !v_we;
          wrNext      = v_we;
          lastVecNext = 1'b1;
        end
      end
      FRd:    stateNext = FData;
      FData:  stateNext = Idle;
      VRd: begin
        // Read data lags the address by one cycle, so the index trails cnt
        idxNext = cnt;
        if (cnt == LastCnt) begin
          stateNext = VDrain;
        end else begin
          cntNext  = cnt + CntW'(1);
          addrNext = Addr + 16'd1;
          rdNext   = 1'b1;
        end
      end
      VDrain: stateNext = Idle;
      VWr: begin
        if (cnt == LastCnt) begin
          stateNext = Idle;
        end else begin
          cntNext  = cnt + CntW'(1);
          addrNext = Addr + 16'd1;
          wrNext   = 1'b1;
          idxNext  = cnt + CntW'(1);
        end
      end
      default: stateNext = Idle;
    endcase
  end

  always_comb begin
    f_gnt    = (state == FRd);
    f_valid  = (state == FData);
    f_data   = f_valid ? DataIn : 16'h0000;
    v_gnt    = ((state == VRd) || (state == VWr)) && (cnt == '0);
    v_rvalid = ((state == VRd) && (cnt != '0)) || (state == VDrain);
    v_rdata  = v_rvalid ? DataIn : 16'h0000;
    v_wready = (state == VWr);
    v_done   = (state == VDrain) || ((state == VWr) && (cnt == LastCnt));
    DataOut  = WR ? v_wdata : 16'h0000;
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: cycle vector table plus directed
// sequences for reset abort, no-preemption and fixed-priority arbitration.
module tb_vmem_arbiter;

  localparam int N = 16;

  logic        Clk1 = 1'b0;
  logic        Reset;
  logic        f_req, v_req, v_we;
  logic [15:0] f_addr, v_base, v_wdata;
  logic [15:0] DataIn, DataIn2;

  logic        f_gnt, f_valid, v_gnt, v_wready, v_rvalid, v_done, RD, WR;
  logic [15:0] f_data, v_rdata, Addr, DataOut;
  logic [3:0]  v_idx;

  logic        f_gnt2, f_valid2, v_gnt2, v_wready2, v_rvalid2, v_done2, RD2, WR2;
  logic [15:0] f_data2, v_rdata2, Addr2, DataOut2;
  logic [3:0]  v_idx2;

  always #5 Clk1 = ~Clk1;

  vmem_arbiter #(.BURST_LEN(N), .PRIORITY_RR(1'b1)) dut (
    .Clk1(Clk1), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_gnt(v_gnt), .v_idx(v_idx),
    .v_wready(v_wready), .v_wdata(v_wdata), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .v_done(v_done), .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
  );

  vmem_arbiter #(.BURST_LEN(N), .PRIORITY_RR(1'b0)) dut2 (
    .Clk1(Clk1), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt2), .f_valid(f_valid2), .f_data(f_data2),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_gnt(v_gnt2), .v_idx(v_idx2),
    .v_wready(v_wready2), .v_wdata(v_wdata), .v_rvalid(v_rvalid2), .v_rdata(v_rdata2),
    .v_done(v_done2), .Addr(Addr2), .RD(RD2), .WR(WR2), .DataOut(DataOut2), .DataIn(DataIn2)
  );

  // Write requester: data word depends on the element index being written
  assign v_wdata = 16'hA000 + 16'(v_idx);

  function automatic logic [15:0] memFn(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1F0A : (a ^ 16'hFFFF);
  endfunction

  always @(posedge Clk1) begin
    DataIn  <= RD  ? memFn(Addr)  : 16'h0000;
    DataIn2 <= RD2 ? memFn(Addr2) : 16'h0000;
  end

  logic [75:0] obsV;
  assign obsV = {f_gnt, f_valid, v_gnt, v_rvalid, v_wready, v_done, RD, WR,
                 v_idx, Addr, f_data, v_rdata, DataOut};

  typedef struct {
    string       tag;
    logic        fReq;
    logic [15:0] fAddr;
    logic        vReq;
    logic        vWe;
    logic [15:0] vBase;
    logic [75:0] expv;
  } vec_t;

  vec_t        vecs[$];
  logic        curF, curV, curWe;
  logic [15:0] curFA, curVB;
  int          nChecks = 0;
  int          nFail   = 0;

  task automatic check(input string tag, input logic [75:0] act, input logic [75:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  function automatic logic [75:0] mkExp(input bit fg, input bit fv, input bit vg, input bit rv,
                                        input bit wrdy, input bit dn, input bit rd, input bit wr,
                                        input int idx, input logic [15:0] addr,
                                        input logic [15:0] fd, input logic [15:0] rdat,
                                        input logic [15:0] dout);
    return {fg, fv, vg, rv, wrdy, dn, rd, wr, 4'(idx), addr, fd, rdat, dout};
  endfunction

  task automatic push(input string tag, input logic [75:0] e);
    vec_t v;
    v.tag = tag; v.fReq = curF; v.fAddr = curFA; v.vReq = curV; v.vWe = curWe;
    v.vBase = curVB; v.expv = e;
    vecs.push_back(v);
  endtask

  task automatic addFetch(input logic [15:0] a, input logic [15:0] d, input bit drop);
    push("fetch_gnt", mkExp(1, 0, 0, 0, 0, 0, 1, 0, 0, a, 16'h0, 16'h0, 16'h0));
    if (drop) curF = 1'b0;
    push("fetch_data", mkExp(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, d, 16'h0, 16'h0));
    push("fetch_idle", '0);
  endtask

  task automatic addRead(input logic [15:0] b, input bit drop);
    push("rd_gnt", mkExp(0, 0, 1, 0, 0, 0, 1, 0, 0, b, 16'h0, 16'h0, 16'h0));
    if (drop) curV = 1'b0;
    for (int k = 1; k < N; k++)
      push("rd_beat", mkExp(0, 0, 0, 1, 0, 0, 1, 0, k - 1, 16'(b + 16'(k)), 16'h0,
                            16'(b + 16'(k - 1)) ^ 16'hFFFF, 16'h0));
    push("rd_drain", mkExp(0, 0, 0, 1, 0, 1, 0, 0, N - 1, 16'h0, 16'h0,
                           16'(b + 16'(N - 1)) ^ 16'hFFFF, 16'h0));
    push("rd_idle", '0);
  endtask

  task automatic addWrite(input logic [15:0] b, input bit drop);
    for (int k = 0; k < N; k++) begin
      push("wr_beat", mkExp(0, 0, k == 0, 0, 1, k == N - 1, 0, 1, k, 16'(b + 16'(k)),
                            16'h0, 16'h0, 16'hA000 + 16'(k)));
      if (drop) curV = 1'b0;
    end
    push("wr_idle", '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitCyc, doneCyc, gntCyc, early, both;
    int f1, v1, f2, v2;
    bit doneSeen;

    Reset = 1'b0; f_req = 1'b0; v_req = 1'b0; v_we = 1'b0;
    f_addr = 16'h0; v_base = 16'h0;
    repeat (2) @(posedge Clk1);
    #1;
    check("reset_outputs", obsV, '0);
    check("reset_outputs_fixed_prio", {f_gnt2, v_gnt2, RD2, WR2, Addr2, DataOut2}, '0);
    Reset = 1'b1;

    // Fetch, burst read, wrapping burst write, then round-robin ties
    curF = 1; curFA = 16'h0040; curV = 0; curWe = 0; curVB = 16'h0;
    addFetch(16'h0040, 16'h1F0A, 1'b1);
    curV = 1; curWe = 0; curVB = 16'h0100;
    addRead(16'h0100, 1'b1);
    curV = 1; curWe = 1; curVB = 16'hFFF8;
    addWrite(16'hFFF8, 1'b1);
    curF = 1; curFA = 16'h0200; curV = 1; curWe = 0; curVB = 16'h0300;
    addFetch(16'h0200, 16'hFDFF, 1'b0);
    addRead(16'h0300, 1'b0);
    addFetch(16'h0200, 16'hFDFF, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      f_req = vecs[i].fReq; f_addr = vecs[i].fAddr;
      v_req = vecs[i].vReq; v_we = vecs[i].vWe; v_base = vecs[i].vBase;
      @(posedge Clk1);
      #1;
      check($sformatf("%s[%0d]", vecs[i].tag, i), obsV, vecs[i].expv);
    end

    // Reset during cycle 7 of a read burst
    f_req = 1'b0; v_req = 1'b1; v_we = 1'b0; v_base = 16'h0500;
    @(posedge Clk1);
    #1;
    check("abort_burst_gnt", {v_gnt, RD}, 2'b11);
    v_req = 1'b0;
    repeat (6) @(posedge Clk1);
    #1;
    check("abort_cycle7", {RD, v_rvalid, v_idx, Addr}, {1'b1, 1'b1, 4'd5, 16'h0506});
    #2 Reset = 1'b0;
    #1;
    check("abort_immediate", {RD, WR, v_rvalid, v_done, v_gnt, Addr}, '0);
    doneSeen = 1'b0;
    repeat (3) begin
      @(posedge Clk1);
      #1;
      doneSeen = doneSeen | v_done | v_rvalid | RD;
    end
    check("abort_no_done", {63'h0, doneSeen}, '0);
    Reset = 1'b1; f_req = 1'b1; f_addr = 16'h0040;
    waitCyc = 0;
    do begin
      @(posedge Clk1);
      #1;
      waitCyc++;
    end while (!f_gnt && waitCyc < 4);
    check("post_reset_fgnt", {f_gnt, RD, Addr}, {1'b1, 1'b1, 16'h0040});
    check("post_reset_latency", waitCyc, 1);
    f_req = 1'b0;
    @(posedge Clk1);
    #1;
    check("post_reset_fdata", {f_valid, f_data}, {1'b1, 16'h1F0A});
    @(posedge Clk1);
    #1;

    // Fetch request raised during a burst write is held off until the burst ends
    v_req = 1'b1; v_we = 1'b1; v_base = 16'h0800;
    @(posedge Clk1);
    #1;
    check("nopreempt_wgnt", {v_gnt, WR}, 2'b11);
    v_req = 1'b0; f_req = 1'b1; f_addr = 16'h0040;
    doneCyc = -1; gntCyc = -1; early = 0; both = 0;
    for (int c = 1; c < 40 && gntCyc < 0; c++) begin
      @(posedge Clk1);
      #1;
      if (RD && WR) both++;
      if (f_gnt) begin
        gntCyc = c;
        if (doneCyc < 0) early++;
      end
      if (v_done) doneCyc = c;
    end
    check("nopreempt_early_fgnt", early, 0);
    check("nopreempt_done_cycle", doneCyc, N - 1);
    check("nopreempt_fgnt_within2",
          {63'h0, (doneCyc >= 0 && gntCyc > doneCyc && gntCyc - doneCyc <= 2)}, 76'd1);
    check("nopreempt_rd_wr_exclusive", both, 0);
    f_req = 1'b0;
    repeat (3) @(posedge Clk1);
    #1;

    // Persistent tie on both instances: round-robin vs fetch-always-wins
    Reset = 1'b0;
    @(posedge Clk1);
    #1;
    Reset = 1'b1;
    f_req = 1'b1; f_addr = 16'h0200; v_req = 1'b1; v_we = 1'b0; v_base = 16'h0300;
    f1 = 0; v1 = 0; f2 = 0; v2 = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk1);
      #1;
      f1 += int'(f_gnt); v1 += int'(v_gnt);
      f2 += int'(f_gnt2); v2 += int'(v_gnt2);
    end
    check("rr_fetch_grants", f1, 2);
    check("rr_vector_grants", v1, 2);
    check("fixed_fetch_grants", f2, 10);
    check("fixed_vector_grants", v2, 0);
    f_req = 1'b0; v_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
